// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding, nibble width
// and index-width helper.
package nibble_serial_subtractor_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Index counter width: $clog2(n), but never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub_stage.sv
// Combinational 4-bit subtract stage: diff = a - b - bin, with the borrow-out
// taken from the fifth bit of a zero-extended subtraction.
module nibble_sub_stage
   import nibble_serial_subtractor_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             bin,
   output logic [NIB_W-1:0] diff,
   output logic             bout
);

   logic [NIB_W:0] full;

   assign full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
   assign diff = full[NIB_W-1:0];
   assign bout = full[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// W-bit a - b - bin computed one nibble per clock, LSB first, through a single
// shared 4-bit subtract stage with the borrow carried in a register.
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIB_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         zero
);

   localparam int               IDX_W    = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               borrow_q, borrow_d;
   logic [W-1:0]       diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [NIB_W-1:0]   nib_a, nib_b, nib_diff;
   logic               nib_bout;

   assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
   assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

   nibble_sub_stage u_stage (
      .a    (nib_a),
      .b    (nib_b),
      .bin  (borrow_q),
      .diff (nib_diff),
      .bout (nib_bout)
   );

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case statement leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      zero_d   = zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               idx_d    = '0;
               diff_d   = '0;
               bout_d   = 1'b0;
               zero_d   = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            diff_d[idx_q*NIB_W +: NIB_W] = nib_diff;
            borrow_d = nib_bout;
            if (idx_q == LAST_IDX) begin
               // zero looks at diff_d so the nibble written this cycle counts.
               idx_d   = '0;
               bout_d  = nib_bout;
               zero_d  = (diff_d == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed scenarios plus
// randomized operands compared against an integer-arithmetic reference model.
module tb_nibble_serial_subtractor;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_i, b_i;
   logic         bin_i;
   logic         busy, done, bout, zero;
   logic [W-1:0] diff;

   int n_tests = 0;
   int n_fail  = 0;

   nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .bin   (bin_i),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // Reference: signed integer subtraction, wrapped into W bits.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, output logic [W-1:0] d,
                                 output logic bo, output logic z);
      longint r;
      r  = longint'(a) - longint'(b) - longint'(bin);
      bo = (r < 0);
      if (r < 0) r = r + (longint'(1) << W);
      d  = r[W-1:0];
      z  = (d == '0);
   endfunction

   // Called on a negedge; returns on the negedge after the start edge.
   task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      a_i   = a;
      b_i   = b;
      bin_i = bin;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles after the start edge until done; scrambles the operand inputs
   // meanwhile since the DUT must have latched them. lat = -1 on timeout.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         a_i   = W'($urandom);
         b_i   = W'($urandom);
         bin_i = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic exercise_op(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic bin);
      logic [W-1:0] ed;
      logic         eb, ez;
      int           lat, bc;
      model(a, b, bin, ed, eb, ez);
      pulse_start(a, b, bin);
      wait_done(lat, bc);
      n_tests++; if (lat !== NIBBLES + 1) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, NIBBLES + 1); end
      n_tests++; if (bc !== NIBBLES) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, NIBBLES); end
      n_tests++; if (diff !== ed) begin n_fail++; $display("FAIL %s diff: got %h expected %h", name, diff, ed); end
      n_tests++; if (bout !== eb) begin n_fail++; $display("FAIL %s bout: got %b expected %b", name, bout, eb); end
      n_tests++; if (zero !== ez) begin n_fail++; $display("FAIL %s zero: got %b expected %b", name, zero, ez); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s after_done done/busy: got %b/%b expected 0/0", name, done, busy); end
      n_tests++; if (diff !== ed || bout !== eb || zero !== ez) begin n_fail++; $display("FAIL %s hold: got %h/%b/%b expected %h/%b/%b", name, diff, bout, zero, ed, eb, ez); end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      bin_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_tests++; if ({busy, done, bout, zero} !== 4'b0000) begin n_fail++; $display("FAIL reset flags busy/done/bout/zero: got %b expected 0000", {busy, done, bout, zero}); end
      n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL reset diff: got %h expected 0000", diff); end
   endtask

   task automatic test_basic();
      exercise_op("5_minus_3", 16'h0005, 16'h0003, 1'b0);
      exercise_op("3_minus_5", 16'h0003, 16'h0005, 1'b0);
      exercise_op("ripple_1000_minus_1", 16'h1000, 16'h0001, 1'b0);
      exercise_op("ripple_8000_minus_1", 16'h8000, 16'h0001, 1'b0);
   endtask

   task automatic test_equal_operands();
      exercise_op("equal_bin0", 16'h1234, 16'h1234, 1'b0);
      exercise_op("equal_bin1", 16'h1234, 16'h1234, 1'b1);
      exercise_op("zero_minus_zero", 16'h0000, 16'h0000, 1'b0);
      exercise_op("zero_minus_zero_bin1", 16'h0000, 16'h0000, 1'b1);
   endtask

   task automatic test_start_while_busy();
      int           ndone = 0;
      logic [W-1:0] seen  = '0;
      pulse_start(16'h00FF, 16'h000F, 1'b0);
      @(negedge clk);
      a_i   = 16'hAAAA;
      b_i   = 16'h5555;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin ndone++; seen = diff; end
         @(negedge clk);
      end
      n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_start done_pulses: got %0d expected 1", ndone); end
      n_tests++; if (seen !== 16'h00F0) begin n_fail++; $display("FAIL busy_start diff: got %h expected 00f0", seen); end
   endtask

   task automatic test_reset_mid_run();
      int ndone = 0;
      pulse_start(16'hFFFF, 16'h0001, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset busy/done: got %b/%b expected 0/0", busy, done); end
      n_tests++; if (diff !== '0 || bout !== 1'b0 || zero !== 1'b0) begin n_fail++; $display("FAIL midreset diff/bout/zero: got %h/%b/%b expected 0000/0/0", diff, bout, zero); end
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL midreset spurious_done: got %0d expected 0", ndone); end
      exercise_op("after_reset_8000_minus_1", 16'h8000, 16'h0001, 1'b0);
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      pulse_start(16'h0009, 16'h0004, 1'b0);
      wait_done(lat, bc);
      n_tests++; if (diff !== 16'h0005 || lat !== NIBBLES + 1) begin n_fail++; $display("FAIL b2b first diff/latency: got %h/%0d expected 0005/%0d", diff, lat, NIBBLES + 1); end
      pulse_start(16'h0010, 16'h0001, 1'b0);
      n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b restart done/busy: got %b/%b expected 0/1", done, busy); end
      n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL b2b cleared diff: got %h expected 0000", diff); end
      wait_done(lat, bc);
      n_tests++; if (lat !== NIBBLES + 1) begin n_fail++; $display("FAIL b2b second latency: got %0d expected %0d", lat, NIBBLES + 1); end
      n_tests++; if (diff !== 16'h000F || bout !== 1'b0) begin n_fail++; $display("FAIL b2b second diff/bout: got %h/%b expected 000f/0", diff, bout); end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
         exercise_op($sformatf("random_%0d", i), ra, rb, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal_operands();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
